// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: state encodings, grant ids and
// the RAM control-bus pin positions.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_VGA = 1'b1
    } arb_grant_e;

    localparam int RAM_READ_PIN  = 0;
    localparam int RAM_WRITE_PIN = 1;
    localparam int RAM_READY_PIN = 0;

    // Exactly one strobe bit set, chosen by the access direction.
    function automatic logic [31:0] strobe_mask(input logic we);
        logic [31:0] mask;
        mask = '0;
        mask[we ? RAM_WRITE_PIN : RAM_READ_PIN] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way grant selector for the RAM arbiter.
// ARB_VGA_PRIORITY_EN: VGA wins every tie; otherwise ties alternate via last_grant_i.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic       cpu_req_i,
    input  logic       vga_req_i,
    input  arb_grant_e last_grant_i,
    output arb_grant_e grant_o
);

`ifdef ARB_VGA_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = 1'(last_grant_i);
`endif

    always_comb begin
        grant_o = ARB_CPU;
        if (cpu_req_i && vga_req_i) begin
`ifdef ARB_VGA_PRIORITY_EN
            grant_o = ARB_VGA;
`else
            grant_o = (last_grant_i == ARB_CPU) ? ARB_VGA : ARB_CPU;
`endif
        end else if (vga_req_i) begin
            grant_o = ARB_VGA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between the CPU datapath (port 0) and the VGA
// fetch engine (port 1), one transaction at a time. Tie policy: ARB_VGA_PRIORITY_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic              vga_we,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [DATA_W-1:0] vga_wdata,
    output logic              vga_ack,
    output logic              vga_err,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [31:0]       ram_ctrl_out,
    input  logic [31:0]       ram_ctrl_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    arb_grant_e        grant_q, grant_d;
    arb_grant_e        last_grant_q, last_grant_d;
    arb_grant_e        pick_grant;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              unused_ctrl_in;

    assign unused_ctrl_in = ^ram_ctrl_in;

    ram_arb_pick u_pick (
        .cpu_req_i   (cpu_req),
        .vga_req_i   (vga_req),
        .last_grant_i(last_grant_q),
        .grant_o     (pick_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= ARB_CPU;
            last_grant_q <= ARB_VGA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            cpu_rdata_q  <= '0;
            vga_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_rdata_q  <= vga_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        cpu_rdata_d  = cpu_rdata_q;
        vga_rdata_d  = vga_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_req || vga_req) begin
                    grant_d = pick_grant;
                    if (pick_grant == ARB_VGA) begin
                        we_d    = vga_we;
                        addr_d  = vga_addr;
                        wdata_d = vga_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                // Ready takes precedence over a timeout landing on the same edge.
                if (ram_ctrl_in[RAM_READY_PIN]) begin
                    if (!we_q) begin
                        if (grant_q == ARB_VGA) vga_rdata_d = data_in;
                        else                    cpu_rdata_d = data_in;
                    end
                    err_d   = 1'b0;
                    state_d = ARB_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ARB_DONE: begin
                last_grant_d = grant_q;
                state_d      = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign ram_ctrl_out = (state_q == ARB_ACCESS) ? strobe_mask(we_q) : '0;
    assign addr         = addr_q;
    assign data_out     = wdata_q;
    assign cpu_ack      = (state_q == ARB_DONE) && (grant_q == ARB_CPU);
    assign vga_ack      = (state_q == ARB_DONE) && (grant_q == ARB_VGA);
    assign cpu_err      = cpu_ack && err_q;
    assign vga_err      = vga_ack && err_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign vga_rdata    = vga_rdata_q;

endmodule
